// File: rtl/xor_parity_bank.sv
// Parity bank: XOR2/XOR3 equations plus a four-stage XOR5 cascade, with optional
// enable-gated output registers cleared by an asynchronous active-high reset.
module xor_parity_bank #(
    parameter int unsigned OUT_REG = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic i4,
    input  logic i5,
    output logic o2,
    output logic o3,
    output logic o5,
    output logic q2,
    output logic q3,
    output logic q5
);

    logic w_t1;
    logic w_t2;
    logic w_t3;

    assign o2 = i1 ^ i2;
    assign o3 = i1 ^ i2 ^ i3;

    // o5 is built as a chain of 2-input stages rather than a reduction
    assign w_t1 = i1 ^ i2;
    assign w_t2 = w_t1 ^ i3;
    assign w_t3 = w_t2 ^ i4;
    assign o5   = w_t3 ^ i5;

    generate
        if (OUT_REG != 0) begin : g_reg
            logic r_q2;
            logic r_q3;
            logic r_q5;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q2 <= 1'b0;
                    r_q3 <= 1'b0;
                    r_q5 <= 1'b0;
                end else if (en) begin
                    r_q2 <= o2;
                    r_q3 <= o3;
                    r_q5 <= o5;
                end
            end

            assign q2 = r_q2;
            assign q3 = r_q3;
            assign q5 = r_q5;
        end else begin : g_comb
            // clk/rst/en have no function in the bypass build
            logic w_unused;
            assign w_unused = clk ^ rst ^ en;

            assign q2 = o2;
            assign q3 = o3;
            assign q5 = o5;
        end
    endgenerate

endmodule

// File: tb/tb_xor_parity_bank.sv
// Self-checking bench for xor_parity_bank: registered and bypass builds side by
// side, driven from shared inputs and checked against a counting parity model.
`timescale 1ns/100ps
module tb_xor_parity_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [4:0] v;

    logic o2, o3, o5, q2, q3, q5;
    logic c_o2, c_o3, c_o5, c_q2, c_q3, c_q5;

    int errors;
    int checks;

    logic [2:0] exp_q;

    xor_parity_bank #(.OUT_REG(1)) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .i1(v[0]), .i2(v[1]), .i3(v[2]), .i4(v[3]), .i5(v[4]),
        .o2(o2), .o3(o3), .o5(o5),
        .q2(q2), .q3(q3), .q5(q5)
    );

    xor_parity_bank #(.OUT_REG(0)) u_dut_comb (
        .clk(clk), .rst(rst), .en(en),
        .i1(v[0]), .i2(v[1]), .i3(v[2]), .i4(v[3]), .i5(v[4]),
        .o2(c_o2), .o3(c_o3), .o5(c_o5),
        .q2(c_q2), .q3(c_q3), .q5(c_q5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns {odd(v[1:0]), odd(v[2:0]), odd(v[4:0])} by counting set bits
    function automatic logic [2:0] ref_par(input logic [4:0] vec);
        int n2 = 0;
        int n3 = 0;
        int n5 = 0;
        for (int k = 0; k < 5; k++) begin
            if (vec[k]) begin
                n5++;
                if (k < 3) n3++;
                if (k < 2) n2++;
            end
        end
        return {1'(n2 % 2), 1'(n3 % 2), 1'(n5 % 2)};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b0;
        v   = 5'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({q2, q3, q5} !== 3'b000) begin
            errors++;
            $display("FAIL reset_no_clk q=%b want=000", {q2, q3, q5});
        end
        exp_q = 3'b000;
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 32; i++) begin
            v = 5'(i);
            #0.1;
            checks++;
            if ({o2, o3, o5} !== ref_par(v)) begin
                errors++;
                $display("FAIL sweep_o v=%0d o=%b want=%b", i, {o2, o3, o5}, ref_par(v));
            end
            checks++;
            if ({c_q2, c_q3, c_q5} !== ref_par(v) || {c_o2, c_o3, c_o5} !== ref_par(v)) begin
                errors++;
                $display("FAIL sweep_bypass v=%0d q=%b o=%b want=%b", i,
                         {c_q2, c_q3, c_q5}, {c_o2, c_o3, c_o5}, ref_par(v));
            end
            checks++;
            if ({q2, q3, q5} !== 3'b000) begin
                errors++;
                $display("FAIL sweep_reset_hold v=%0d q=%b want=000", i, {q2, q3, q5});
            end
        end
    endtask

    task automatic test_fixed_vector();
        v = 5'b10110;
        #1;
        checks++;
        if ({o2, o3, o5} !== 3'b101) begin
            errors++;
            $display("FAIL vec_10110 o=%b want=101", {o2, o3, o5});
        end
    endtask

    task automatic test_capture();
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        v   = 5'b00111;
        @(posedge clk);
        #1;
        checks++;
        if ({q2, q3, q5} !== 3'b011) begin
            errors++;
            $display("FAIL capture q=%b want=011", {q2, q3, q5});
        end
        exp_q = 3'b011;
    endtask

    task automatic test_hold();
        @(negedge clk);
        en = 1'b0;
        v  = 5'b00001;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({q2, q3, q5} !== 3'b011 || {o2, o3, o5} !== 3'b111) begin
                errors++;
                $display("FAIL hold q=%b o=%b want q=011 o=111", {q2, q3, q5}, {o2, o3, o5});
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({q2, q3, q5} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset q=%b want=000", {q2, q3, q5});
        end
        v = 5'b11100;
        #1;
        checks++;
        if ({o2, o3, o5} !== ref_par(5'b11100)) begin
            errors++;
            $display("FAIL o_during_reset o=%b want=%b", {o2, o3, o5}, ref_par(5'b11100));
        end
        en = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({q2, q3, q5} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ignores_clk q=%b want=000", {q2, q3, q5});
        end
        exp_q = 3'b000;
    endtask

    task automatic test_back_to_back();
        logic [4:0] seq [4] = '{5'b00011, 5'b10101, 5'b01000, 5'b11111};
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = seq[i];
            @(posedge clk);
            #1;
            exp_q = ref_par(seq[i]);
            checks++;
            if ({q2, q3, q5} !== exp_q) begin
                errors++;
                $display("FAIL back_to_back step=%0d q=%b want=%b", i, {q2, q3, q5}, exp_q);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            v   = 5'($urandom);
            en  = 1'($urandom);
            rst = ($urandom_range(0, 9) == 0);
            #1;
            if (rst) exp_q = 3'b000;
            checks++;
            if ({q2, q3, q5} !== exp_q) begin
                errors++;
                $display("FAIL rand_mid i=%0d q=%b want=%b", i, {q2, q3, q5}, exp_q);
            end
            @(posedge clk);
            #1;
            if (!rst && en) exp_q = ref_par(v);
            checks++;
            if ({q2, q3, q5} !== exp_q || {o2, o3, o5} !== ref_par(v)) begin
                errors++;
                $display("FAIL rand_edge i=%0d v=%b q=%b o=%b want q=%b o=%b", i, v,
                         {q2, q3, q5}, {o2, o3, o5}, exp_q, ref_par(v));
            end
            checks++;
            if ({c_q2, c_q3, c_q5} !== ref_par(v)) begin
                errors++;
                $display("FAIL rand_bypass i=%0d q=%b want=%b", i, {c_q2, c_q3, c_q5},
                         ref_par(v));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_sweep();
        test_fixed_vector();
        test_capture();
        test_hold();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
